// File: rtl/guess_scorer_pkg.sv
// Shared game definitions: scorer state encoding, pin colour type and
// board RAM layout defaults, also used by the top-level game FSM.
package guess_scorer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GREEN,
    S_YELLOW,
    S_HINT_Y,
    S_HINT_G,
    S_FIN
  } scorer_state_e;

  localparam int PIN_COLOR_W_DEF  = 5;
  localparam int HINTS_OFFSET_DEF = 2048;

  typedef logic [PIN_COLOR_W_DEF-1:0] pin_color_t;

  // Effective pin count: requested count clamped to the board width.
  function automatic logic [4:0] eff_pins(input logic [4:0] cnt, input int max_pins);
    logic [4:0] lim;
    lim = 5'(max_pins);
    return (cnt > lim) ? lim : cnt;
  endfunction

endpackage

// File: rtl/guess_scorer.sv
// Scores one guess against the secret: exact matches first (one pin per
// cycle, each pin also logged to board RAM), then an exhaustive pair scan
// for colour-only matches, then the two hint counts are written to RAM.
module guess_scorer
  import guess_scorer_pkg::*;
#(
  parameter int MAX_PINS     = 8,
  parameter int PIN_COLOR_W  = PIN_COLOR_W_DEF,
  parameter int RAM_ADDR_W   = 12,
  parameter int HINTS_OFFSET = HINTS_OFFSET_DEF
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic                            START,
  input  logic                            ABORT,
  input  logic [MAX_PINS*PIN_COLOR_W-1:0] GUESS,
  input  logic [MAX_PINS*PIN_COLOR_W-1:0] SECRET,
  input  logic [4:0]                      PINS_COUNT,
  input  logic [7:0]                      ROW,
  output logic                            BUSY,
  output logic                            DONE,
  output logic [4:0]                      GREEN,
  output logic [4:0]                      YELLOW,
  output logic                            WIN,
  output logic                            RAM_WEN,
  output logic [RAM_ADDR_W-1:0]           RAM_WADDR,
  output logic [7:0]                      RAM_WDATA
);

  localparam int IDX_W  = (MAX_PINS > 1) ? $clog2(MAX_PINS) : 1;
  localparam int AW_EXT = RAM_ADDR_W + 8;

  scorer_state_e                   state_q;
  logic [MAX_PINS*PIN_COLOR_W-1:0] guess_q;
  logic [MAX_PINS*PIN_COLOR_W-1:0] secret_q;
  logic [7:0]                      row_q;
  logic [4:0]                      p_q;
  logic [4:0]                      pin_q;
  logic [4:0]                      g_q;
  logic [4:0]                      s_q;
  logic [4:0]                      green_cnt_q;
  logic [4:0]                      yellow_cnt_q;
  logic [MAX_PINS-1:0]             gmask_q;
  logic [MAX_PINS-1:0]             smask_q;
  logic [4:0]                      green_q;
  logic [4:0]                      yellow_q;
  logic                            win_q;
  logic                            done_q;

  logic [PIN_COLOR_W-1:0] guess_pin  [MAX_PINS];
  logic [PIN_COLOR_W-1:0] secret_pin [MAX_PINS];

  // Unpack the latched colour vectors into per-pin arrays.
  generate
    for (genvar gi = 0; gi < MAX_PINS; gi++) begin : g_unpack
      assign guess_pin[gi]  = guess_q[gi*PIN_COLOR_W +: PIN_COLOR_W];
      assign secret_pin[gi] = secret_q[gi*PIN_COLOR_W +: PIN_COLOR_W];
    end
  endgenerate

  // Indices are always below P <= MAX_PINS, so the narrow views are exact.
  logic [IDX_W-1:0] pin_idx, g_idx, s_idx;
  assign pin_idx = pin_q[IDX_W-1:0];
  assign g_idx   = g_q[IDX_W-1:0];
  assign s_idx   = s_q[IDX_W-1:0];

  logic [4:0] start_p_d;
  logic       green_hit_d, yellow_hit_d;
  logic       last_pin_d, last_g_d, last_s_d;

  assign start_p_d    = eff_pins(PINS_COUNT, MAX_PINS);
  assign green_hit_d  = (guess_pin[pin_idx] == secret_pin[pin_idx]);
  assign yellow_hit_d = (g_q != s_q) && (guess_pin[g_idx] == secret_pin[s_idx]) &&
                        !gmask_q[g_idx] && !smask_q[s_idx];
  assign last_pin_d   = (pin_q == p_q - 5'd1);
  assign last_g_d     = (g_q == p_q - 5'd1);
  assign last_s_d     = (s_q == p_q - 5'd1);

  // Scoring FSM: sequencing, match masks, counters and held results.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      guess_q      <= '0;
      secret_q     <= '0;
      row_q        <= '0;
      p_q          <= '0;
      pin_q        <= '0;
      g_q          <= '0;
      s_q          <= '0;
      green_cnt_q  <= '0;
      yellow_cnt_q <= '0;
      gmask_q      <= '0;
      smask_q      <= '0;
      green_q      <= '0;
      yellow_q     <= '0;
      win_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE && ABORT) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (START && !ABORT) begin
              guess_q      <= GUESS;
              secret_q     <= SECRET;
              row_q        <= ROW;
              p_q          <= start_p_d;
              pin_q        <= '0;
              g_q          <= '0;
              s_q          <= '0;
              green_cnt_q  <= '0;
              yellow_cnt_q <= '0;
              gmask_q      <= '0;
              smask_q      <= '0;
              state_q      <= (start_p_d == 5'd0) ? S_HINT_Y : S_GREEN;
            end
          end
          S_GREEN: begin
            if (green_hit_d) begin
              gmask_q[pin_idx] <= 1'b1;
              smask_q[pin_idx] <= 1'b1;
              green_cnt_q      <= green_cnt_q + 5'd1;
            end
            if (last_pin_d) state_q <= S_YELLOW;
            else            pin_q   <= pin_q + 5'd1;
          end
          S_YELLOW: begin
            if (yellow_hit_d) begin
              gmask_q[g_idx] <= 1'b1;
              smask_q[s_idx] <= 1'b1;
              yellow_cnt_q   <= yellow_cnt_q + 5'd1;
            end
            if (last_s_d) begin
              s_q <= '0;
              if (last_g_d) state_q <= S_HINT_Y;
              else          g_q     <= g_q + 5'd1;
            end else begin
              s_q <= s_q + 5'd1;
            end
          end
          S_HINT_Y: state_q <= S_HINT_G;
          S_HINT_G: state_q <= S_FIN;
          S_FIN: begin
            green_q  <= green_cnt_q;
            yellow_q <= yellow_cnt_q;
            win_q    <= (green_cnt_q == p_q) && (p_q != 5'd0);
            done_q   <= 1'b1;
            state_q  <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  logic                  ram_wen_d;
  logic [RAM_ADDR_W-1:0] ram_waddr_d;
  logic [7:0]            ram_wdata_d;

  // Board RAM write port, decoded from state; an abort kills the write at once.
  always_comb begin
    ram_wen_d   = 1'b0;
    ram_waddr_d = '0;
    ram_wdata_d = '0;
    if (!ABORT) begin
      case (state_q)
        S_GREEN: begin
          ram_wen_d   = 1'b1;
          ram_waddr_d = RAM_ADDR_W'(AW_EXT'(row_q) * AW_EXT'(MAX_PINS) + AW_EXT'(pin_q));
          ram_wdata_d = 8'(guess_pin[pin_idx]);
        end
        S_HINT_Y: begin
          ram_wen_d   = 1'b1;
          ram_waddr_d = RAM_ADDR_W'(AW_EXT'(HINTS_OFFSET) + (AW_EXT'(row_q) << 1));
          ram_wdata_d = 8'(yellow_cnt_q);
        end
        S_HINT_G: begin
          ram_wen_d   = 1'b1;
          ram_waddr_d = RAM_ADDR_W'(AW_EXT'(HINTS_OFFSET) + (AW_EXT'(row_q) << 1) + AW_EXT'(1));
          ram_wdata_d = 8'(green_cnt_q);
        end
        default: ;
      endcase
    end
  end

  assign BUSY      = (state_q != S_IDLE);
  assign DONE      = done_q;
  assign GREEN     = green_q;
  assign YELLOW    = yellow_q;
  assign WIN       = win_q;
  assign RAM_WEN   = ram_wen_d;
  assign RAM_WADDR = ram_waddr_d;
  assign RAM_WDATA = ram_wdata_d;

endmodule

// File: tb/tb_guess_scorer.sv
// Bench for guess_scorer: table of scoring vectors with a result
// scoreboard and a board RAM capture, plus abort/reset/busy sequences.
module tb_guess_scorer;
  import guess_scorer_pkg::*;

  localparam int MP = 8;
  localparam int CW = 5;
  localparam int AW = 12;
  localparam int NV = 8;

  logic           CLK = 1'b0;
  logic           RST_N = 1'b0;
  logic           START = 1'b0;
  logic           ABORT = 1'b0;
  logic [MP*CW-1:0] GUESS = '0;
  logic [MP*CW-1:0] SECRET = '0;
  logic [4:0]     PINS_COUNT = '0;
  logic [7:0]     ROW = '0;
  logic           BUSY, DONE, WIN, RAM_WEN;
  logic [4:0]     GREEN, YELLOW;
  logic [AW-1:0]  RAM_WADDR;
  logic [7:0]     RAM_WDATA;

  guess_scorer #(
    .MAX_PINS(MP), .PIN_COLOR_W(CW), .RAM_ADDR_W(AW), .HINTS_OFFSET(2048)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT),
    .GUESS(GUESS), .SECRET(SECRET), .PINS_COUNT(PINS_COUNT), .ROW(ROW),
    .BUSY(BUSY), .DONE(DONE), .GREEN(GREEN), .YELLOW(YELLOW), .WIN(WIN),
    .RAM_WEN(RAM_WEN), .RAM_WADDR(RAM_WADDR), .RAM_WDATA(RAM_WDATA)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [MP*CW-1:0] sec;
    logic [MP*CW-1:0] gue;
    logic [4:0]       pins;
    logic [7:0]       row;
    int               eg;
    int               ey;
    int               ew;
  } vec_t;

  typedef struct {
    int vi;
    int eg;
    int ey;
    int ew;
    int elat;
    int start_cyc;
    int wr0;
  } sb_t;

  vec_t vecs [NV];
  sb_t  exp_q [$];

  logic [7:0] mem [0:(1<<AW)-1];
  int cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int checks = 0;
  int failures = 0;

  // Board RAM capture and event counters.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RAM_WEN) begin
      mem[RAM_WADDR] <= RAM_WDATA;
      wr_cnt <= wr_cnt + 1;
    end
    if (DONE) done_cnt <= done_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [MP*CW-1:0] pk(input int a0, input int a1, input int a2, input int a3,
                                          input int a4, input int a5, input int a6, input int a7);
    logic [MP*CW-1:0] r;
    r = {5'(a7), 5'(a6), 5'(a5), 5'(a4), 5'(a3), 5'(a2), 5'(a1), 5'(a0)};
    return r;
  endfunction

  function automatic int pin_of(input logic [MP*CW-1:0] v, input int j);
    return int'(v[j*CW +: CW]);
  endfunction

  function automatic int eff_p(input logic [4:0] pins);
    return (int'(pins) > MP) ? MP : int'(pins);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; drives one START cycle and books the expectation.
  task automatic start_vec(input int i);
    sb_t e;
    int  p;
    p = eff_p(vecs[i].pins);
    GUESS = vecs[i].gue;
    SECRET = vecs[i].sec;
    PINS_COUNT = vecs[i].pins;
    ROW = vecs[i].row;
    START = 1'b1;
    e.vi = i;
    e.eg = vecs[i].eg;
    e.ey = vecs[i].ey;
    e.ew = vecs[i].ew;
    e.elat = 3 + p + p * p;
    e.start_cyc = cyc + 1;
    e.wr0 = wr_cnt;
    exp_q.push_back(e);
    @(negedge CLK);
    START = 1'b0;
    check("busy_after_start", int'(BUSY), 1);
  endtask

  task automatic wait_done();
    sb_t e;
    int  n;
    int  p;
    int  base;
    n = 0;
    while (DONE !== 1'b1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) begin
      check("done_timeout", 0, 1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    p = eff_p(vecs[e.vi].pins);
    base = int'(vecs[e.vi].row) * MP;
    $display("txn vec=%0d green=%0d yellow=%0d win=%0d latency=%0d",
             e.vi, GREEN, YELLOW, WIN, cyc - e.start_cyc);
    check($sformatf("v%0d_latency", e.vi), cyc - e.start_cyc, e.elat);
    check($sformatf("v%0d_green", e.vi), int'(GREEN), e.eg);
    check($sformatf("v%0d_yellow", e.vi), int'(YELLOW), e.ey);
    check($sformatf("v%0d_win", e.vi), int'(WIN), e.ew);
    check($sformatf("v%0d_busy_at_done", e.vi), int'(BUSY), 0);
    check($sformatf("v%0d_write_count", e.vi), wr_cnt - e.wr0, p + 2);
    for (int j = 0; j < p; j++)
      check($sformatf("v%0d_ram_pin%0d", e.vi, j), int'(mem[base + j]), pin_of(vecs[e.vi].gue, j));
    check($sformatf("v%0d_ram_hint_y", e.vi), int'(mem[2048 + 2 * int'(vecs[e.vi].row)]), e.ey);
    check($sformatf("v%0d_ram_hint_g", e.vi), int'(mem[2049 + 2 * int'(vecs[e.vi].row)]), e.eg);
    @(negedge CLK);
    check($sformatf("v%0d_done_pulse", e.vi), int'(DONE), 0);
    check($sformatf("v%0d_green_held", e.vi), int'(GREEN), e.eg);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, int'(BUSY), 0);
    check({tag, "_done"}, int'(DONE), 0);
    check({tag, "_green"}, int'(GREEN), 0);
    check({tag, "_yellow"}, int'(YELLOW), 0);
    check({tag, "_win"}, int'(WIN), 0);
    check({tag, "_wen"}, int'(RAM_WEN), 0);
    check({tag, "_waddr"}, int'(RAM_WADDR), 0);
    check({tag, "_wdata"}, int'(RAM_WDATA), 0);
  endtask

  initial begin
    int w0;
    int d0;
    // Unused pin slots carry equal colours so any scan past P shows up.
    vecs[0] = '{pk(1,1,2,3,17,17,17,17), pk(1,2,1,4,17,17,17,17), 5'd4,  8'd0,   1, 2, 0};
    vecs[1] = '{pk(0,0,0,1,17,17,17,17), pk(0,1,1,1,17,17,17,17), 5'd4,  8'd5,   2, 0, 0};
    vecs[2] = '{pk(3,4,5,2,17,17,17,17), pk(3,4,5,2,17,17,17,17), 5'd4,  8'd1,   4, 0, 1};
    vecs[3] = '{pk(17,17,17,17,17,17,17,17), pk(17,17,17,17,17,17,17,17), 5'd0, 8'd2, 0, 0, 0};
    vecs[4] = '{pk(1,2,3,4,5,6,7,8), pk(8,7,6,5,4,3,2,1), 5'd20, 8'd3,   0, 8, 0};
    vecs[5] = '{pk(7,7,7,7,7,7,7,7), pk(7,7,7,7,7,7,7,7), 5'd8,  8'd4,   8, 0, 1};
    vecs[6] = '{pk(9,17,17,17,17,17,17,17), pk(9,17,17,17,17,17,17,17), 5'd1, 8'd255, 1, 0, 1};
    vecs[7] = '{pk(2,2,5,17,17,17,17,17), pk(5,2,2,17,17,17,17,17), 5'd3,  8'd6,   1, 2, 0};

    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    check_all_zero("reset");

    @(negedge CLK);
    for (int i = 0; i < NV; i++) begin
      start_vec(i);
      wait_done();
    end

    // Abort in the third YELLOW cycle after a known result.
    start_vec(0);
    wait_done();
    d0 = done_cnt;
    GUESS = vecs[2].gue; SECRET = vecs[2].sec; PINS_COUNT = vecs[2].pins; ROW = vecs[2].row;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (6) @(negedge CLK);
    ABORT = 1'b1;
    #1;
    check("abort_y_busy_before", int'(BUSY), 1);
    check("abort_y_wen", int'(RAM_WEN), 0);
    @(negedge CLK);
    ABORT = 1'b0;
    check("abort_y_idle", int'(BUSY), 0);
    check("abort_y_green_held", int'(GREEN), 1);
    check("abort_y_yellow_held", int'(YELLOW), 2);
    check("abort_y_win_held", int'(WIN), 0);
    start_vec(1);
    wait_done();
    check("abort_y_single_done", done_cnt - d0, 1);

    // Abort during GREEN suppresses that cycle's write immediately.
    START = 1'b1;
    GUESS = vecs[0].gue; SECRET = vecs[0].sec; PINS_COUNT = vecs[0].pins; ROW = vecs[0].row;
    @(negedge CLK);
    START = 1'b0;
    check("abort_g_wen_before", int'(RAM_WEN), 1);
    ABORT = 1'b1;
    #1;
    check("abort_g_wen", int'(RAM_WEN), 0);
    check("abort_g_waddr", int'(RAM_WADDR), 0);
    @(negedge CLK);
    ABORT = 1'b0;
    check("abort_g_idle", int'(BUSY), 0);
    check("abort_g_green_held", int'(GREEN), 2);

    // ABORT and START together in IDLE: START dropped.
    START = 1'b1;
    ABORT = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    ABORT = 1'b0;
    check("abort_start_idle", int'(BUSY), 0);

    // START while busy is ignored; vector 0 still completes untouched.
    @(negedge CLK);
    start_vec(0);
    repeat (2) @(negedge CLK);
    GUESS = vecs[2].gue; SECRET = vecs[2].sec; ROW = vecs[2].row; PINS_COUNT = 5'd8;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done();

    // Reset for one cycle during GREEN discards the run.
    GUESS = vecs[0].gue; SECRET = vecs[0].sec; PINS_COUNT = vecs[0].pins; ROW = vecs[0].row;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    check_all_zero("midreset");
    w0 = wr_cnt;
    d0 = done_cnt;
    repeat (30) @(negedge CLK);
    check("midreset_no_writes", wr_cnt - w0, 0);
    check("midreset_no_done", done_cnt - d0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
